// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: bundle between the IF stage, the decode-stage control and the
// instruction ROM. The slave modport is the fetch stage itself; the master
// modport is the surrounding pipeline (D-stage control, hazard unit, ROM).
interface ifu_fetch_if;
  logic        stall;
  logic        clr_d;
  logic [1:0]  npc_op;
  logic        br_cond;
  logic [15:0] imm16_d;
  logic [25:0] imm26_d;
  logic [31:0] rs_val_d;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        exc_adel_d;

  modport slave (
    input  stall, clr_d, npc_op, br_cond, imm16_d, imm26_d, rs_val_d, im_instr,
    output im_addr, instr_d, pc_d, pc8_d, exc_adel_d
  );

  modport master (
    output stall, clr_d, npc_op, br_cond, imm16_d, imm26_d, rs_val_d, im_instr,
    input  im_addr, instr_d, pc_d, pc8_d, exc_adel_d
  );
endinterface

// File: rtl/ifu_fetch_stage.sv
// ifu_fetch_stage: IF stage of the five-stage MIPS pipeline. Holds the fetch
// PC, selects next-PC from D-stage control (delay-slot semantics, no flush on
// taken branches) and owns the IF/ID pipeline register.
// Optional macro IFU_ADEL_CHECK_EN: when defined, misaligned or out-of-window
// fetch addresses load a nop into IF/ID and raise exc_adel_d; when undefined
// exc_adel_d stays 0 and the ROM word is always taken.
module ifu_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input logic         clk,
  input logic         reset,
  ifu_fetch_if.slave  bus
);

  localparam logic [1:0] NPC_SEQ    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

  logic [31:0] pc_f_reg;
  logic [31:0] instr_d_reg;
  logic [31:0] pc_d_reg;
  logic [31:0] pc8_d_reg;
  logic        exc_adel_d_reg;

  logic [31:0] pc_f_plus4;
  logic [31:0] pc_d_plus4;
  logic [31:0] br_offset;
  logic [31:0] npc;
  logic        fetch_err;

  assign pc_f_plus4 = pc_f_reg + 32'd4;
  assign pc_d_plus4 = pc_d_reg + 32'd4;
  assign br_offset  = {{14{bus.imm16_d[15]}}, bus.imm16_d, 2'b00};

`ifdef IFU_ADEL_CHECK_EN
  // Upper bound of the legal fetch window (exclusive), modulo 2^32.
  localparam logic [31:0] PC_LIMIT = PC_RESET + 32'(4 * IM_WORDS);

  // Fetch address error: misaligned word or outside the ROM window.
  always_comb begin
    fetch_err = (pc_f_reg[1:0] != 2'b00) ||
                (pc_f_reg < PC_RESET) ||
                (pc_f_reg >= PC_LIMIT);
  end
`else
  assign fetch_err = 1'b0;
`endif

  // Next-PC select; branch/jump targets are relative to the instruction in D.
  always_comb begin
    npc = pc_f_plus4;
    case (bus.npc_op)
      NPC_SEQ:    npc = pc_f_plus4;
      NPC_BRANCH: npc = bus.br_cond ? (pc_d_plus4 + br_offset) : pc_f_plus4;
      NPC_JUMP:   npc = {pc_d_plus4[31:28], bus.imm26_d, 2'b00};
      NPC_JR:     npc = bus.rs_val_d;
      default:    npc = pc_f_plus4;
    endcase
  end

  // PC and IF/ID update: reset > stall > clr_d > normal fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_reg       <= PC_RESET;
      instr_d_reg    <= 32'd0;
      pc_d_reg       <= PC_RESET;
      pc8_d_reg      <= PC_RESET + 32'd8;
      exc_adel_d_reg <= 1'b0;
    end else if (!bus.stall) begin
      pc_f_reg  <= npc;
      pc_d_reg  <= pc_f_reg;
      pc8_d_reg <= pc_f_reg + 32'd8;
      // A bubble or a bad fetch both present a nop to decode; only the latter
      // is flagged, since a bubble carries no instruction to fault on.
      if (bus.clr_d || fetch_err) begin
        instr_d_reg <= 32'd0;
      end else begin
        instr_d_reg <= bus.im_instr;
      end
      exc_adel_d_reg <= !bus.clr_d && fetch_err;
    end
  end

  assign bus.im_addr    = pc_f_reg;
  assign bus.instr_d    = instr_d_reg;
  assign bus.pc_d       = pc_d_reg;
  assign bus.pc8_d      = pc8_d_reg;
  assign bus.exc_adel_d = exc_adel_d_reg;

endmodule

// File: doc/ifu_fetch_stage.md
Name: ifu_fetch_stage

Overview:
- IF stage of the P5 five-stage MIPS pipeline.
- Holds the fetch PC and drives it to the instruction ROM (word index = address bits [11:2]). Takes back the combinational instruction word.
- Computes next-PC from D-stage control: sequential, branch, j/jal, or jr. Uses architectural delay-slot semantics, so no flush is generated on a taken branch.
- Owns the IF/ID pipeline register that feeds the decode stage.

Parameters:
- PC_RESET, 32'h0000_3000, fetch PC value after reset.
- IM_WORDS, 1024, ROM depth in words; defines the legal fetch window [PC_RESET, PC_RESET+4*IM_WORDS).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit stall; freezes PC and IF/ID.
- clr_d  input  1  bubble-insert into IF/ID (exception/eret path).
- npc_op  input  2  from D stage: 0 = PC+4, 1 = branch, 2 = j/jal, 3 = jr.
- br_cond  input  1  D-stage comparator result; used only when npc_op=1.
- imm16_d  input  16  branch offset field of the D instruction.
- imm26_d  input  26  jump index field of the D instruction.
- rs_val_d  input  32  forwarded GPR[rs] for jr.
- im_addr  output  32  current fetch PC (pc_f) to the ROM.
- im_instr  input  32  instruction word returned by the ROM (combinational).
- instr_d  output  32  IF/ID instruction.
- pc_d  output  32  IF/ID PC.
- pc8_d  output  32  IF/ID PC+8 (link value).
- exc_adel_d  output  1  IF/ID fetch-address error flag (see Optional Feature).

Behaviour:
- Registers: pc_f, instr_d, pc_d, pc8_d, exc_adel_d.
- On reset: pc_f=PC_RESET; instr_d=0; pc_d=PC_RESET; pc8_d=PC_RESET+8; exc_adel_d=0.
- im_addr = pc_f, combinational. Fetch latency: the instruction at pc_f appears on instr_d one cycle later.
- Next-PC (npc), combinational. All adds are 32-bit modulo 2^32; wrap-around is not an error in npc itself.
  - npc_op=0: pc_f+4.
  - npc_op=1 and br_cond=1: pc_d+4+(sext(imm16_d)<<2).
  - npc_op=1 and br_cond=0: pc_f+4.
  - npc_op=2: {(pc_d+4)[31:28], imm26_d, 2'b00}.
  - npc_op=3: rs_val_d, unmodified (low bits not masked).
- Per-edge priority: reset > stall > clr_d > normal.
- stall=1:
  - pc_f and all IF/ID registers hold.
  - npc is discarded. D holds too, so the redirect is re-evaluated the next unstalled cycle.
- stall=0, clr_d=1:
  - pc_f <= npc.
  - instr_d <= 0 (nop), exc_adel_d <= 0.
  - pc_d <= pc_f, pc8_d <= pc_f+8. PC is kept for EPC/debug.
- stall=0, clr_d=0:
  - pc_f <= npc.
  - instr_d <= im_instr, pc_d <= pc_f, pc8_d <= pc_f+8.
  - exc_adel_d <= fetch-error of pc_f.
- stall=1 and clr_d=1 together: stall wins; clr_d is ignored that cycle.
- Delay slot: the instruction fetched in the cycle a branch/jump resolves in D enters IF/ID normally and is never squashed by this block.
- Reset asserted mid-stream overrides stall/clr_d. The first post-reset edge with reset=0 fetches PC_RESET+4 into pc_f and the PC_RESET instruction into instr_d.

Optional Feature:
- Macro: IFU_ADEL_CHECK_EN.
- Defined: fetch-error = (pc_f[1:0]!=0) OR pc_f < PC_RESET OR pc_f >= PC_RESET+4*IM_WORDS.
  - On error, instr_d is loaded with 0 instead of im_instr and exc_adel_d=1. pc_d carries the bad PC.
  - pc_f still advances per npc.
- Not defined: exc_adel_d is constant 0 and instr_d always takes im_instr. Port list is unchanged.

Test Plan:
- Reset held 3 cycles, then released with npc_op=0 -> pc_f sequence 0x3000, 0x3004, 0x3008. instr_d equals ROM[0], ROM[1] on successive edges. pc8_d=0x3008 when pc_d=0x3000.
- Branch: pc_d=0x3010, npc_op=1, br_cond=1, imm16_d=16'hFFFC -> next pc_f=0x3004. The delay-slot instr at 0x3014 reaches instr_d. With br_cond=0 -> pc_f=0x3018.
- j with pc_d=0x3020, imm26_d=26'h0000C10 -> pc_f=0x3040. jr with rs_val_d=0x3100 -> pc_f=0x3100.
- stall high 2 cycles during npc_op=1, br_cond=1 -> pc_f and IF/ID frozen. Redirect applied on the first unstalled edge. stall+clr_d together -> IF/ID unchanged.
- clr_d pulse with pc_f=0x3024 -> instr_d=0, pc_d=0x3024, pc8_d=0x302C. The next edge resumes normal fetch.
- IFU_ADEL_CHECK_EN defined, jr to 0x3002 -> exc_adel_d=1, instr_d=0, pc_d=0x3002. jr to 0x4000 (IM_WORDS=1024) -> exc_adel_d=1. Macro undefined: same stimulus -> exc_adel_d=0, instr_d=ROM word.
